image_pixel_fetch: RTL and testbench

IMAGE_PIXEL_FETCH -- requirements
Module: image_pixel_fetch

---
 rtl/img_pkg.sv | 27 ++
 rtl/strobe_delay.sv | 62 ++++++
 rtl/image_pixel_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_image_pixel_fetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Shared constants and helpers for the image pixel fetch path.
//               WIN_DIM  - displayed window edge in pixels (2x upscaled image)
//               IMG_DIM  - stored image edge in pixels
//               ADDR_W   - BRAM address width (bank bit + 16-bit pixel index)
//               expand_rgb332() - RRRGGGBB to RGB888 by bit replication
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

  localparam int WIN_DIM = 480;
  localparam int IMG_DIM = 240;
  localparam int ADDR_W  = 17;

  // Bit replication maps full-scale codes to 8'hFF and zero to 8'h00, so
  // white and black survive the expansion exactly.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

endpackage : img_pkg
`default_nettype wire

// File: rtl/strobe_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : strobe_delay
// Description : Single-bit shift register of DEPTH stages, asynchronous
//               active-high reset. Used to align timing strobes and the
//               in-window flag with the pixel pipeline.
// Ports       : clk   in  1  clock
//               reset in  1  asynchronous active-high reset (clears all stages)
//               din   in  1  strobe input
//               dout  out 1  strobe delayed by DEPTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH <= 1) begin : g_single
      logic stage_q;
      logic stage_d;

      always_comb begin
        stage_d = din;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_q <= 1'b0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q;
    end else begin : g_chain
      logic [DEPTH-1:0] stage_q;
      logic [DEPTH-1:0] stage_d;

      always_comb begin
        stage_d = {stage_q[DEPTH-2:0], din};
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule : strobe_delay
`default_nettype wire

// File: rtl/image_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : image_pixel_fetch
// Description : Fetches an IMG_DIM x IMG_DIM RRRGGGBB image from BRAM and
//               displays it 2x upscaled in a 2*IMG_DIM square window at the
//               top-left of the raster. Pixels outside the window show
//               BORDER_COLOR, blanked pixels show black. Fixed latency of
//               RD_LAT+2 cycles from hcount/vcount to pixel, no stalls.
// Config      : IMG_DOUBLE_BUFFER_EN - when defined, addr[16] selects one of
//               two image banks; swap_req is latched and the bank flips at
//               hcount==0, vcount==2*IMG_DIM, followed by a swap_ack pulse.
//               When undefined, addr[16]=0, swap_req is ignored, swap_ack=0.
// Ports       : clk        in  1   pixel clock
//               reset      in  1   asynchronous active-high reset
//               hcount     in  10  pixel column
//               vcount     in  10  pixel row
//               hsync/vsync/blank in 1 timing strobes aligned with counts
//               addr       out 17  BRAM address {bank, pixel index}
//               bram_data  in  8   RRRGGGBB, valid RD_LAT cycles after addr
//               swap_req   in  1   request a bank flip
//               swap_ack   out 1   pulse when the bank has flipped
//               pixel      out 24  RGB888
//               hsync_out/vsync_out/blank_out out 1 strobes aligned to pixel
// Revision    : 1.0 - initial release
// ============================================================================
module image_pixel_fetch #(
  parameter int          RD_LAT       = 2,          // legal range 1..4
  parameter logic [23:0] BORDER_COLOR = 24'h000000,
  parameter int          IMG_DIM      = img_pkg::IMG_DIM
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      blank,
  output logic [img_pkg::ADDR_W-1:0] addr,
  input  logic [7:0]                bram_data,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic [23:0]               pixel,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_out
);

  import img_pkg::*;

  // Address register, RD_LAT BRAM cycles, output register.
  localparam int          LAT        = RD_LAT + 2;
  localparam logic [9:0]  WIN_LIM    = 10'(2 * IMG_DIM);
  localparam logic [15:0] ROW_STRIDE = 16'(IMG_DIM);

  // --------------------------------------------------------------------------
  // Stage 0: window test and pixel index
  // --------------------------------------------------------------------------
  logic        in_win;
  logic [8:0]  h_half;
  logic [8:0]  v_half;
  logic [15:0] pix_idx;
  logic        bank_d;

  always_comb begin
    in_win  = (hcount < WIN_LIM) && (vcount < WIN_LIM);
    // Each coordinate is clamped on its own so the row base stays meaningful
    // in the horizontal border and the index never leaves the image.
    h_half  = (hcount < WIN_LIM) ? hcount[9:1] : 9'd0;
    v_half  = (vcount < WIN_LIM) ? vcount[9:1] : 9'd0;
    pix_idx = {7'd0, h_half} + ({7'd0, v_half} * ROW_STRIDE);
  end

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    // Uses the next bank value so the first address issued after the swap
    // point already points into the newly selected bank.
    addr_d = {bank_d, pix_idx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

  // --------------------------------------------------------------------------
  // Bank selection
  // --------------------------------------------------------------------------
`ifdef IMG_DOUBLE_BUFFER_EN
  logic swap_point;
  logic bank_q;
  logic pending_q;
  logic pending_d;
  logic swap_ack_q;
  logic swap_ack_d;

  always_comb begin
    swap_point = (hcount == 10'd0) && (vcount == WIN_LIM);
    bank_d     = bank_q;
    // Folding swap_req in first lets a request that lands on the swap point
    // itself be honoured, and merges repeated requests into one flip.
    pending_d  = pending_q | swap_req;
    swap_ack_d = 1'b0;
    if (swap_point && pending_d) begin
      bank_d     = ~bank_q;
      pending_d  = 1'b0;
      swap_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q     <= 1'b0;
      pending_q  <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      pending_q  <= pending_d;
      swap_ack_q <= swap_ack_d;
    end
  end

  assign swap_ack = swap_ack_q;
`else
  logic unused_swap_req;

  assign bank_d          = 1'b0;
  assign swap_ack        = 1'b0;
  assign unused_swap_req = swap_req;
`endif

  // --------------------------------------------------------------------------
  // Strobe alignment. blank and the window flag stop one stage short because
  // they steer the output register, which supplies the final stage.
  // --------------------------------------------------------------------------
  logic blank_dly;
  logic win_dly;

  strobe_delay #(.DEPTH(LAT)) u_hsync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (hsync),
    .dout  (hsync_out)
  );

  strobe_delay #(.DEPTH(LAT)) u_vsync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .dout  (vsync_out)
  );

  strobe_delay #(.DEPTH(LAT - 1)) u_blank_dly (
    .clk   (clk),
    .reset (reset),
    .din   (blank),
    .dout  (blank_dly)
  );

  strobe_delay #(.DEPTH(LAT - 1)) u_win_dly (
    .clk   (clk),
    .reset (reset),
    .din   (in_win),
    .dout  (win_dly)
  );

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic [23:0] pixel_q;
  logic [23:0] pixel_d;
  logic        blank_out_q;
  logic        blank_out_d;

  always_comb begin
    blank_out_d = blank_dly;
    if (blank_dly) begin
      pixel_d = 24'h000000;
    end else if (!win_dly) begin
      pixel_d = BORDER_COLOR;
    end else begin
      pixel_d = expand_rgb332(bram_data);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_q     <= 24'h000000;
      blank_out_q <= 1'b0;
    end else begin
      pixel_q     <= pixel_d;
      blank_out_q <= blank_out_d;
    end
  end

  assign pixel     = pixel_q;
  assign blank_out = blank_out_q;

endmodule : image_pixel_fetch
`default_nettype wire

// File: tb/tb_image_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_image_pixel_fetch
// Description : Self-checking bench for image_pixel_fetch. Three instances
//               (RD_LAT 1, 2, 4) share one stimulus stream; each sees its
//               own BRAM model. A history of inputs plus a bank/pending model
//               gives the expected outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_pixel_fetch;

  localparam int MAXC = 8192;
`ifdef IMG_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       hsync = 1'b0, vsync = 1'b0, blank = 1'b0, swap_req = 1'b0;

  logic [16:0] a1, a2, a4;
  logic [7:0]  d1, d2, d4;
  logic [23:0] p1, p2, p4;
  logic        hs1, hs2, hs4, vs1, vs2, vs4, bo1, bo2, bo4, k1, k2, k4;

  always #5 clk = ~clk;

  image_pixel_fetch #(.RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .addr(a1), .bram_data(d1),
    .swap_req(swap_req), .swap_ack(k1), .pixel(p1),
    .hsync_out(hs1), .vsync_out(vs1), .blank_out(bo1));

  image_pixel_fetch #(.RD_LAT(2), .BORDER_COLOR(24'h123456)) u2 (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .addr(a2), .bram_data(d2),
    .swap_req(swap_req), .swap_ack(k2), .pixel(p2),
    .hsync_out(hs2), .vsync_out(vs2), .blank_out(bo2));

  image_pixel_fetch #(.RD_LAT(4)) u4 (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .addr(a4), .bram_data(d4),
    .swap_req(swap_req), .swap_ack(k4), .pixel(p4),
    .hsync_out(hs4), .vsync_out(vs4), .blank_out(bo4));

  // ---------------- BRAM models ----------------
  logic [7:0] mem [0:131071];
  logic [7:0] q1;
  logic [7:0] q2 [0:1];
  logic [7:0] q4 [0:3];

  always @(posedge clk) begin
    q1    <= mem[a1];
    q2[0] <= mem[a2];
    q2[1] <= q2[0];
    q4[0] <= mem[a4];
    q4[1] <= q4[0];
    q4[2] <= q4[1];
    q4[3] <= q4[2];
  end
  assign d1 = q1;
  assign d2 = q2[1];
  assign d4 = q4[3];

  // ---------------- history and model ----------------
  bit [9:0] hc_h [0:MAXC-1];
  bit [9:0] vc_h [0:MAXC-1];
  bit       hs_h [0:MAXC-1];
  bit       vs_h [0:MAXC-1];
  bit       bl_h [0:MAXC-1];
  bit       rst_h [0:MAXC-1];
  bit       bank_h [0:MAXC-1];
  bit       ack_h [0:MAXC-1];
  bit       m_bank = 1'b0;
  bit       m_pend = 1'b0;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int pin_a0 = -100, pin_amax = -100, pin_a1200 = -100, pin_ff = -100;
  int pin_e0 = -100, pin_bd = -100, pin_bk = -100, pin_hs = -100;
  int pin_sw1 = -100, pin_sw2 = -100, pin_sw3 = -100;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_rst(input int k);
    if (k < 0 || k >= MAXC) return 1'b1;
    return rst_h[k];
  endfunction

  function automatic int idx_of(input int k);
    int h, v;
    h = (hc_h[k] < 480) ? int'(hc_h[k]) : 0;
    v = (vc_h[k] < 480) ? int'(vc_h[k]) : 0;
    return h / 2 + (v / 2) * 240;
  endfunction

  function automatic logic [23:0] expand_ref(input logic [7:0] d);
    int r, g, b;
    r = int'(d[7:5]);
    g = int'(d[4:2]);
    b = int'(d[1:0]);
    r = (r << 5) | (r << 2) | (r >> 1);
    g = (g << 5) | (g << 2) | (g >> 1);
    b = b * 85;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic logic [23:0] exp_pix(input int k, input logic [23:0] border);
    int a;
    if (bl_h[k]) return 24'h0;
    if (!(hc_h[k] < 480 && vc_h[k] < 480)) return border;
    a = idx_of(k) + (bank_h[k] ? 65536 : 0);
    return expand_ref(mem[a]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic chk_inst(input string nm, input int lat, input logic [23:0] border,
                          input logic [16:0] a, input logic [23:0] p,
                          input logic hso, input logic vso, input logic blo,
                          input logic ack);
    int  c;
    bit  ok;
    c = cyc;
    if (is_rst(c)) begin
      chk({nm, ".rst_addr"}, 32'(a), 0);
      chk({nm, ".rst_pixel"}, 32'(p), 0);
      chk({nm, ".rst_strobes"}, {29'd0, hso, vso, blo}, 0);
      chk({nm, ".rst_ack"}, 32'(ack), 0);
    end else begin
      if (is_rst(c - 1)) begin
        chk({nm, ".addr"}, 32'(a), 0);
        chk({nm, ".ack"}, 32'(ack), 0);
      end else begin
        chk({nm, ".addr"}, 32'(a), 32'(idx_of(c - 1) + (bank_h[c - 1] ? 65536 : 0)));
        chk({nm, ".ack"}, 32'(ack), 32'(ack_h[c - 1]));
      end
      ok = 1'b1;
      for (int k = c - lat; k <= c; k++) if (is_rst(k)) ok = 1'b0;
      if (ok) begin
        chk({nm, ".pixel"}, 32'(p), 32'(exp_pix(c - lat, border)));
        chk({nm, ".strobes"}, {29'd0, hso, vso, blo},
            {29'd0, hs_h[c - lat], vs_h[c - lat], bl_h[c - lat]});
      end
    end
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs,
                       input bit bl, input bit sr, input bit rs);
    @(posedge clk);
    #1;
    hcount = h[9:0]; vcount = v[9:0];
    hsync = hs; vsync = vs; blank = bl; swap_req = sr; reset = rs;
    if (cyc < MAXC) begin
      hc_h[cyc] = h[9:0]; vc_h[cyc] = v[9:0];
      hs_h[cyc] = hs; vs_h[cyc] = vs; bl_h[cyc] = bl; rst_h[cyc] = rs;
      ack_h[cyc] = 1'b0;
      if (rs) begin
        m_bank = 1'b0;
        m_pend = 1'b0;
      end else if (DB) begin
        if (sr) m_pend = 1'b1;
        if (h == 0 && v == 480) begin
          if (m_pend) begin
            m_bank = ~m_bank;
            ack_h[cyc] = 1'b1;
          end
          m_pend = 1'b0;
        end
      end
      bank_h[cyc] = m_bank;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk_inst("u1", 3, 24'h0,      a1, p1, hs1, vs1, bo1, k1);
      chk_inst("u2", 4, 24'h123456, a2, p2, hs2, vs2, bo2, k2);
      chk_inst("u4", 6, 24'h0,      a4, p4, hs4, vs4, bo4, k4);
      if (cyc == pin_a0 + 1)    chk("lit.addr_origin", 32'(a2), 32'd0);
      if (cyc == pin_amax + 1)  chk("lit.addr_max", 32'(a2), 32'd57599);
      if (cyc == pin_a1200 + 1) chk("lit.addr_hclamp", 32'(a2), 32'd1200);
      if (cyc == pin_ff + 3)    chk("lit.white_lat1", 32'(p1), 32'hFFFFFF);
      if (cyc == pin_ff + 4)    chk("lit.white_lat2", 32'(p2), 32'hFFFFFF);
      if (cyc == pin_ff + 6)    chk("lit.white_lat4", 32'(p4), 32'hFFFFFF);
      if (cyc == pin_e0 + 4)    chk("lit.red", 32'(p2), 32'hFF0000);
      if (cyc == pin_bd + 4)    chk("lit.border", 32'(p2), 32'h123456);
      if (cyc == pin_bk + 4)    chk("lit.blanked", 32'(p2), 32'h0);
      if (cyc == pin_hs + 3)    chk("lit.hsync_early", 32'(hs2), 32'd0);
      if (cyc == pin_hs + 4)    chk("lit.hsync_L", 32'(hs2), 32'd1);
      if (cyc == pin_sw1 + 1)   chk("lit.swap1_bank", {a2[16], k2}, {DB, DB});
      if (cyc == pin_sw2 + 1)   chk("lit.swap2_bank", {a2[16], k2}, {1'b0, DB});
      if (cyc == pin_sw2 + 2)   chk("lit.swap2_single", 32'(k2), 32'd0);
      if (cyc == pin_sw3 + 1)   chk("lit.swap3_same_cycle", {a2[16], k2}, {DB, DB});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int h, v;
    for (int i = 0; i < MAXC; i++) rst_h[i] = 1'b1;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[1205] = 8'hFF;
    mem[1210] = 8'hE0;

    repeat (4) drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) drive(700, 500, 0, 0, 1, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);     pin_a0 = cyc;
    drive(479, 479, 0, 0, 0, 0, 0); pin_amax = cyc;
    drive(500, 10, 0, 0, 0, 0, 0);  pin_a1200 = cyc;
    drive(10, 10, 0, 0, 0, 0, 0);   pin_ff = cyc;
    drive(20, 10, 0, 0, 0, 0, 0);   pin_e0 = cyc;
    drive(600, 5, 0, 0, 0, 0, 0);   pin_bd = cyc;
    drive(600, 5, 0, 0, 1, 0, 0);   pin_bk = cyc;
    drive(100, 100, 1, 0, 0, 0, 0); pin_hs = cyc;
    repeat (6) drive(100, 100, 0, 0, 0, 0, 0);
    for (int i = 478; i <= 481; i++) drive(i, 200, 0, 1, i[0], 0, 0);
    for (int i = 478; i <= 481; i++) drive(30, i, 1, 0, 0, 0, 0);
    repeat (6) drive(5, 5, 0, 0, 0, 0, 0);

    drive(5, 100, 0, 0, 0, 1, 0);
    repeat (5) drive(40, 300, 0, 0, 0, 0, 0);
    drive(0, 480, 0, 1, 1, 0, 0);   pin_sw1 = cyc;
    repeat (3) drive(1, 480, 0, 1, 1, 0, 0);
    drive(3, 100, 0, 0, 0, 1, 0);
    drive(7, 101, 0, 0, 0, 1, 0);
    repeat (3) drive(9, 300, 0, 0, 0, 0, 0);
    drive(0, 480, 0, 1, 1, 0, 0);   pin_sw2 = cyc;
    repeat (3) drive(2, 480, 0, 1, 1, 0, 0);
    drive(0, 480, 0, 1, 1, 1, 0);   pin_sw3 = cyc;
    repeat (6) drive(60, 199, 1, 0, 0, 0, 0);

    // Mid-frame reset with bank 1 (double-buffer build); outputs must clear
    // immediately, not at the next edge.
    drive(50, 200, 1, 1, 0, 0, 1);
    #1;
    chk("async.addr", 32'(a2), 0);
    chk("async.pixel", 32'(p2), 0);
    chk("async.strobes", {29'd0, hs2, vs2, bo2}, 0);
    chk("async.ack", 32'(k2), 0);
    repeat (2) drive(51, 200, 0, 0, 0, 0, 1);
    repeat (8) drive(52, 200, 0, 0, 0, 0, 0);

    repeat (2500) begin
      case ($urandom_range(0, 5))
        0: h = 0;
        1: h = 479;
        2: h = 480;
        3: h = $urandom_range(0, 1023);
        4: h = $urandom_range(0, 479);
        default: h = $urandom_range(477, 482);
      endcase
      case ($urandom_range(0, 4))
        0: v = 479;
        1: v = 480;
        2: v = $urandom_range(0, 1023);
        default: v = $urandom_range(0, 479);
      endcase
      if ($urandom_range(0, 15) == 0) begin
        h = 0;
        v = 480;
      end
      drive(h, v, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (10) drive(800, 600, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_image_pixel_fetch
`default_nettype wire
